// File: rtl/des_pkg.sv
// Shared DES round-datapath definitions: S-box geometry, sequencer state encoding
// and the eight DES substitution tables with a row/column lookup helper.
package des_pkg;

   localparam int unsigned SBOX_IN_W  = 6;
   localparam int unsigned SBOX_OUT_W = 4;
   localparam int unsigned NUM_SBOX   = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      DONE   = 2'd2
   } state_e;

   // Each table holds 64 nibbles, row-major (row 0 col 0 in the top nibble).
   localparam logic [255:0] SBOX_TABLE [NUM_SBOX] = '{
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FAB1E7608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
   };

   // Outer bits {x[5],x[0]} pick the row, inner bits x[4:1] the column.
   function automatic logic [SBOX_OUT_W-1:0] sbox_eval(input logic [255:0] tbl,
                                                      input logic [SBOX_IN_W-1:0] x);
      logic [5:0]   idx;
      logic [255:0] sh;
      idx = {x[5], x[0], x[4:1]};
      sh  = tbl >> (4 * (63 - int'(idx)));
      return sh[SBOX_OUT_W-1:0];
   endfunction

endpackage

// File: rtl/S_Box_1.sv
// DES S-box 1: 6-bit chunk to 4-bit substitution.
module S_Box_1
   import des_pkg::*;
(
   input  logic [SBOX_IN_W-1:0]  i_data,
   output logic [SBOX_OUT_W-1:0] o_data
);
   assign o_data = sbox_eval(SBOX_TABLE[0], i_data);
endmodule

// File: rtl/S_Box_2.sv
// DES S-box 2: 6-bit chunk to 4-bit substitution.
module S_Box_2
   import des_pkg::*;
(
   input  logic [SBOX_IN_W-1:0]  i_data,
   output logic [SBOX_OUT_W-1:0] o_data
);
   assign o_data = sbox_eval(SBOX_TABLE[1], i_data);
endmodule

// File: rtl/S_Box_3.sv
// DES S-box 3: 6-bit chunk to 4-bit substitution.
module S_Box_3
   import des_pkg::*;
(
   input  logic [SBOX_IN_W-1:0]  i_data,
   output logic [SBOX_OUT_W-1:0] o_data
);
   assign o_data = sbox_eval(SBOX_TABLE[2], i_data);
endmodule

// File: rtl/S_Box_4.sv
// DES S-box 4: 6-bit chunk to 4-bit substitution.
module S_Box_4
   import des_pkg::*;
(
   input  logic [SBOX_IN_W-1:0]  i_data,
   output logic [SBOX_OUT_W-1:0] o_data
);
   assign o_data = sbox_eval(SBOX_TABLE[3], i_data);
endmodule

// File: rtl/S_Box_5.sv
// DES S-box 5: 6-bit chunk to 4-bit substitution.
module S_Box_5
   import des_pkg::*;
(
   input  logic [SBOX_IN_W-1:0]  i_data,
   output logic [SBOX_OUT_W-1:0] o_data
);
   assign o_data = sbox_eval(SBOX_TABLE[4], i_data);
endmodule

// File: rtl/S_Box_6.sv
// DES S-box 6: 6-bit chunk to 4-bit substitution.
module S_Box_6
   import des_pkg::*;
(
   input  logic [SBOX_IN_W-1:0]  i_data,
   output logic [SBOX_OUT_W-1:0] o_data
);
   assign o_data = sbox_eval(SBOX_TABLE[5], i_data);
endmodule

// File: rtl/S_Box_7.sv
// DES S-box 7: 6-bit chunk to 4-bit substitution.
module S_Box_7
   import des_pkg::*;
(
   input  logic [SBOX_IN_W-1:0]  i_data,
   output logic [SBOX_OUT_W-1:0] o_data
);
   assign o_data = sbox_eval(SBOX_TABLE[6], i_data);
endmodule

// File: rtl/S_Box_8.sv
// DES S-box 8: 6-bit chunk to 4-bit substitution.
module S_Box_8
   import des_pkg::*;
(
   input  logic [SBOX_IN_W-1:0]  i_data,
   output logic [SBOX_OUT_W-1:0] o_data
);
   assign o_data = sbox_eval(SBOX_TABLE[7], i_data);
endmodule

// File: rtl/sbox_select_lookup.sv
// Shared combinational S-box path: all eight boxes see the same chunk and the
// box index selects which result is used.
module sbox_select_lookup
   import des_pkg::*;
(
   input  logic [2:0]            i_idx,
   input  logic [SBOX_IN_W-1:0]  i_chunk,
   output logic [SBOX_OUT_W-1:0] o_value
);

   logic [SBOX_OUT_W-1:0] box_out [NUM_SBOX];

   S_Box_1 u_s1 (.i_data(i_chunk), .o_data(box_out[0]));
   S_Box_2 u_s2 (.i_data(i_chunk), .o_data(box_out[1]));
   S_Box_3 u_s3 (.i_data(i_chunk), .o_data(box_out[2]));
   S_Box_4 u_s4 (.i_data(i_chunk), .o_data(box_out[3]));
   S_Box_5 u_s5 (.i_data(i_chunk), .o_data(box_out[4]));
   S_Box_6 u_s6 (.i_data(i_chunk), .o_data(box_out[5]));
   S_Box_7 u_s7 (.i_data(i_chunk), .o_data(box_out[6]));
   S_Box_8 u_s8 (.i_data(i_chunk), .o_data(box_out[7]));

   assign o_value = box_out[i_idx];

endmodule

// File: rtl/sbox_serial_sequencer.sv
// Serial DES f-function substitution: one 6->4 lookup per cycle, 32-bit result
// with valid/ready handshake. Define SBOX_REG_EN to register the lookup result.
module sbox_serial_sequencer
   import des_pkg::*;
#(
   parameter int unsigned NUM_BOXES    = 8,
   parameter bit          ZERO_ON_IDLE = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [47:0] i_data,
   input  logic        i_valid,
   output logic        o_ready,
   output logic [31:0] o_data,
   output logic        o_valid,
   input  logic        i_ready,
   output logic        o_busy
);

   if (NUM_BOXES != NUM_SBOX) begin : g_bad_num_boxes
      $error("sbox_serial_sequencer: NUM_BOXES must be %0d", NUM_SBOX);
   end

   state_e                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [47:0]           cap_q, cap_d;
   logic [31:0]           data_q, data_d;
   logic [SBOX_IN_W-1:0]  chunk;
   logic [SBOX_OUT_W-1:0] sbox_val;

`ifdef SBOX_REG_EN
   logic [SBOX_OUT_W-1:0] pipe_q, pipe_d;
   logic [2:0]            pidx_q, pidx_d;
   logic                  pvld_q, pvld_d;
`endif

   assign chunk = cap_q[47 - 6*int'(cnt_q) -: SBOX_IN_W];

   sbox_select_lookup u_lookup (
      .i_idx   (cnt_q),
      .i_chunk (chunk),
      .o_value (sbox_val)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cap_q   <= '0;
         data_q  <= '0;
`ifdef SBOX_REG_EN
         pipe_q  <= '0;
         pidx_q  <= '0;
         pvld_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cap_q   <= cap_d;
         data_q  <= data_d;
`ifdef SBOX_REG_EN
         pipe_q  <= pipe_d;
         pidx_q  <= pidx_d;
         pvld_q  <= pvld_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cap_d   = cap_q;
      data_d  = data_q;
`ifdef SBOX_REG_EN
      pipe_d  = pipe_q;
      pidx_d  = pidx_q;
      pvld_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (i_valid) begin
               cap_d   = i_data;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
`ifdef SBOX_REG_EN
            // Nibble k lands one edge after chunk k is issued; cnt parks at 7
            // for the final write-only edge.
            if (pvld_q)
               data_d[31 - 4*int'(pidx_q) -: SBOX_OUT_W] = pipe_q;
            if (pvld_q && pidx_q == 3'd7) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               pipe_d = sbox_val;
               pidx_d = cnt_q;
               pvld_d = 1'b1;
               if (cnt_q != 3'd7)
                  cnt_d = cnt_q + 3'd1;
            end
`else
            data_d[31 - 4*int'(cnt_q) -: SBOX_OUT_W] = sbox_val;
            if (cnt_q == 3'd7) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
`endif
         end
         DONE: begin
            cnt_d = '0;
            if (i_ready) begin
               state_d = IDLE;
               if (ZERO_ON_IDLE)
                  data_d = '0;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   assign o_data  = data_q;
   assign o_valid = (state_q == DONE);
   assign o_ready = (state_q == IDLE);
   assign o_busy  = (state_q == LOOKUP) || (state_q == DONE);

endmodule
